// File: rtl/dm_ctrl_if.sv
// Bundle for the MEM-stage data-memory controller: pipeline request/response
// side plus the word-oriented memory port.
interface dm_ctrl_if;
  logic        req_valid;
  logic        req_we;
  logic [1:0]  req_type;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_byteen;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  // master: pipeline + memory model driving the controller
  modport master (
    output req_valid, req_we, req_type, req_addr, req_wdata, mem_ack, mem_rdata,
    input  stall, resp_valid, resp_err, resp_rdata,
           mem_req, mem_we, mem_addr, mem_byteen, mem_wdata
  );

  // slave: the controller itself
  modport slave (
    input  req_valid, req_we, req_type, req_addr, req_wdata, mem_ack, mem_rdata,
    output stall, resp_valid, resp_err, resp_rdata,
           mem_req, mem_we, mem_addr, mem_byteen, mem_wdata
  );
endinterface

// File: rtl/dm_ctrl.sv
// Data-memory access controller: aligns byte/half/word requests onto a word
// memory port, sign-extends loads and bounds each access with a 16-cycle timeout.
module dm_ctrl (
  input logic     clk,
  input logic     reset,
  dm_ctrl_if.slave bus
);
  localparam int unsigned DW  = 32;
  localparam int unsigned BEW = 4;
  localparam int unsigned CW  = 4;
  localparam logic [CW-1:0] CNT_LAST = CW'(15);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            mem_req_q, mem_req_d;
  logic            mem_we_q, mem_we_d;
  logic [DW-1:0]   mem_addr_q, mem_addr_d;
  logic [BEW-1:0]  mem_byteen_q, mem_byteen_d;
  logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
  logic            resp_valid_q, resp_valid_d;
  logic            resp_err_q, resp_err_d;
  logic [DW-1:0]   resp_rdata_q, resp_rdata_d;
  logic [1:0]      typ_q, typ_d;
  logic [1:0]      off_q, off_d;

  logic            req_err_c;
  logic [BEW-1:0]  byteen_c;
  logic [DW-1:0]   wdata_c;
  logic [15:0]     half_c;
  logic [7:0]      byte_c;
  logic [DW-1:0]   load_c;

  // request decode: legality, lane enables and replicated store data
  always_comb begin
    req_err_c = 1'b0;
    byteen_c  = '0;
    wdata_c   = '0;
    case (bus.req_type)
      2'b00: begin
        req_err_c = (bus.req_addr[1:0] != 2'b00);
        byteen_c  = 4'b1111;
        wdata_c   = bus.req_wdata;
      end
      2'b01: begin
        req_err_c = bus.req_addr[0];
        byteen_c  = bus.req_addr[1] ? 4'b1100 : 4'b0011;
        wdata_c   = {2{bus.req_wdata[15:0]}};
      end
      2'b10: begin
        byteen_c  = 4'b0001 << bus.req_addr[1:0];
        wdata_c   = {4{bus.req_wdata[7:0]}};
      end
      default: req_err_c = 1'b1;
    endcase
  end

  // load lane extraction from the latched type/offset
  always_comb begin
    half_c = off_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    case (off_q)
      2'd0:    byte_c = bus.mem_rdata[7:0];
      2'd1:    byte_c = bus.mem_rdata[15:8];
      2'd2:    byte_c = bus.mem_rdata[23:16];
      default: byte_c = bus.mem_rdata[31:24];
    endcase
    case (typ_q)
      2'b00:   load_c = bus.mem_rdata;
      2'b01:   load_c = {{16{half_c[15]}}, half_c};
      default: load_c = {{24{byte_c[7]}}, byte_c};
    endcase
  end

  // next state and next values of every registered output
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    mem_req_d    = 1'b0;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_byteen_d = mem_byteen_q;
    mem_wdata_d  = mem_wdata_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = resp_rdata_q;
    typ_d        = typ_q;
    off_d        = off_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          if (req_err_c) begin
            state_d      = DONE;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = '0;
          end else begin
            state_d      = WAIT;
            mem_req_d    = 1'b1;
            mem_we_d     = bus.req_we;
            mem_addr_d   = {bus.req_addr[31:2], 2'b00};
            mem_byteen_d = byteen_c;
            mem_wdata_d  = wdata_c;
            typ_d        = bus.req_type;
            off_d        = bus.req_addr[1:0];
            cnt_d        = '0;
          end
        end
      end
      WAIT: begin
        // ack has priority, so an ack on the last counted cycle still succeeds
        if (bus.mem_ack) begin
          state_d      = DONE;
          resp_valid_d = 1'b1;
          resp_rdata_d = mem_we_q ? '0 : load_c;
        end else if (cnt_q == CNT_LAST) begin
          state_d      = DONE;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
          resp_rdata_d = '0;
        end else begin
          mem_req_d = 1'b1;
          cnt_d     = cnt_q + CW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_byteen_q <= '0;
      mem_wdata_q  <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      typ_q        <= '0;
      off_q        <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_byteen_q <= mem_byteen_d;
      mem_wdata_q  <= mem_wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
      typ_q        <= typ_d;
      off_q        <= off_d;
    end
  end

  // stall must act in the request cycle itself, hence combinational
  assign bus.stall      = ((state_q == IDLE) && bus.req_valid) || (state_q == WAIT);
  assign bus.mem_req    = mem_req_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_byteen = mem_byteen_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_rdata = resp_rdata_q;
endmodule

// File: tb/tb_dm_ctrl.sv
// Directed bench for dm_ctrl: a table of single accesses with hand-computed
// results, followed by reset, DONE and stray-ack corner sequences.
module tb_dm_ctrl;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  dm_ctrl_if bus ();
  dm_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [1:0]  typ;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          ack_at;
    logic        eerr;
    logic [31:0] eaddr;
    logic [3:0]  ebe;
    logic [31:0] ewdata;
    logic [31:0] erdata;
    int          ereq;
    int          elat;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int  cyc = 0, widx = 0, req_cycles = 0, lat = -1;
    bit  got = 0, bus_ok = 1, stall_ok = 1;
    logic        err_seen;
    logic [31:0] rdata_seen;
    string tag = $sformatf("v%0d", idx);
    bus.req_valid = 1'b1;
    bus.req_we    = v.we;
    bus.req_type  = v.typ;
    bus.req_addr  = v.addr;
    bus.req_wdata = v.wdata;
    bus.mem_rdata = v.rdata;
    #1;
    chk({tag, "_stall_req"}, 32'(bus.stall), 32'd1);
    while (!got && cyc < 40) begin
      step();
      cyc++;
      bus.req_valid = 1'b0;
      bus.mem_ack   = 1'b0;
      if (bus.mem_req) begin
        req_cycles++;
        if (bus.mem_addr !== v.eaddr || bus.mem_byteen !== v.ebe ||
            bus.mem_wdata !== v.ewdata || bus.mem_we !== v.we) bus_ok = 0;
        if (bus.stall !== 1'b1) stall_ok = 0;
        if (widx == v.ack_at) bus.mem_ack = 1'b1;
        widx++;
      end
      if (bus.resp_valid) begin
        got        = 1;
        lat        = cyc;
        err_seen   = bus.resp_err;
        rdata_seen = bus.resp_rdata;
        chk({tag, "_stall_done"}, 32'(bus.stall), 32'd0);
      end
    end
    bus.mem_ack = 1'b0;
    chk({tag, "_resp_seen"}, 32'(got), 32'd1);
    if (got) begin
      chk({tag, "_latency"}, 32'(lat), 32'(v.elat));
      chk({tag, "_req_cycles"}, 32'(req_cycles), 32'(v.ereq));
      chk({tag, "_err"}, 32'(err_seen), 32'(v.eerr));
      chk({tag, "_rdata"}, rdata_seen, v.erdata);
      if (v.ereq > 0) begin
        chk({tag, "_bus"}, 32'(bus_ok), 32'd1);
        chk({tag, "_stall_wait"}, 32'(stall_ok), 32'd1);
      end
      step();
      chk({tag, "_valid_pulse"}, 32'(bus.resp_valid), 32'd0);
      chk({tag, "_req_off"}, 32'(bus.mem_req), 32'd0);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [1:0] typ,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] rdata, input int ack_at,
                              input logic eerr, input logic [3:0] ebe,
                              input logic [31:0] ewdata, input logic [31:0] erdata,
                              input int ereq, input int elat);
    vec_t v;
    v.we = we; v.typ = typ; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
    v.ack_at = ack_at; v.eerr = eerr; v.eaddr = {addr[31:2], 2'b00};
    v.ebe = ebe; v.ewdata = ewdata; v.erdata = erdata; v.ereq = ereq; v.elat = elat;
    return v;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_mem_req"},    32'(bus.mem_req), 32'd0);
    chk({tag, "_mem_we"},     32'(bus.mem_we), 32'd0);
    chk({tag, "_mem_addr"},   bus.mem_addr, 32'd0);
    chk({tag, "_mem_byteen"}, 32'(bus.mem_byteen), 32'd0);
    chk({tag, "_mem_wdata"},  bus.mem_wdata, 32'd0);
    chk({tag, "_resp_valid"}, 32'(bus.resp_valid), 32'd0);
    chk({tag, "_resp_err"},   32'(bus.resp_err), 32'd0);
    chk({tag, "_resp_rdata"}, bus.resp_rdata, 32'd0);
    chk({tag, "_stall"},      32'(bus.stall), 32'd0);
  endtask

  initial begin
    //        we  typ    addr          wdata         rdata         ack err be       ewdata        erdata      req lat
    vecs[0]  = mk(0, 2'b10, 32'h0000_1003, 32'h1234_5678, 32'h80FF_1234, 0, 0, 4'b1000, 32'h7878_7878, 32'hFFFF_FF80, 1, 2);
    vecs[1]  = mk(1, 2'b01, 32'h0000_2002, 32'h0000_BEEF, 32'hDEAD_BEEF, 0, 0, 4'b1100, 32'hBEEF_BEEF, 32'h0000_0000, 1, 2);
    vecs[2]  = mk(0, 2'b00, 32'h0000_3001, 32'h0000_0000, 32'h1111_1111, 0, 1, 4'b0000, 32'h0,         32'h0000_0000, 0, 1);
    vecs[3]  = mk(0, 2'b00, 32'h0000_5004, 32'h1122_3344, 32'hCAFE_F00D, 2, 0, 4'b1111, 32'h1122_3344, 32'hCAFE_F00D, 3, 4);
    vecs[4]  = mk(0, 2'b01, 32'h0000_6000, 32'h0000_ABCD, 32'h1234_8001, 1, 0, 4'b0011, 32'hABCD_ABCD, 32'hFFFF_8001, 2, 3);
    vecs[5]  = mk(0, 2'b01, 32'h0000_6002, 32'h0000_0000, 32'h7FFE_8001, 0, 0, 4'b1100, 32'h0000_0000, 32'h0000_7FFE, 1, 2);
    vecs[6]  = mk(0, 2'b10, 32'h0000_7001, 32'h0000_00AB, 32'h0000_7F00, 0, 0, 4'b0010, 32'hABAB_ABAB, 32'h0000_007F, 1, 2);
    vecs[7]  = mk(1, 2'b10, 32'h0000_7002, 32'h0000_00C3, 32'hFFFF_FFFF, 0, 0, 4'b0100, 32'hC3C3_C3C3, 32'h0000_0000, 1, 2);
    vecs[8]  = mk(0, 2'b11, 32'h0000_8000, 32'h0000_0000, 32'h0000_0000, 0, 1, 4'b0000, 32'h0,         32'h0000_0000, 0, 1);
    vecs[9]  = mk(1, 2'b01, 32'h0000_8003, 32'h0000_1234, 32'h0000_0000, 0, 1, 4'b0000, 32'h0,         32'h0000_0000, 0, 1);
    vecs[10] = mk(0, 2'b00, 32'h0000_9000, 32'h0000_0000, 32'h5555_5555, -1, 1, 4'b1111, 32'h0000_0000, 32'h0000_0000, 16, 17);
    vecs[11] = mk(1, 2'b00, 32'h0000_A004, 32'h89AB_CDEF, 32'h0000_0000, 3, 0, 4'b1111, 32'h89AB_CDEF, 32'h0000_0000, 4, 5);
    vecs[12] = mk(0, 2'b10, 32'h0000_C000, 32'h0000_0000, 32'h0000_0080, 0, 0, 4'b0001, 32'h0000_0000, 32'hFFFF_FF80, 1, 2);
    vecs[13] = mk(0, 2'b01, 32'h0000_4000, 32'h0000_0000, 32'h0000_7FFF, 15, 0, 4'b0011, 32'h0000_0000, 32'h0000_7FFF, 16, 17);

    reset = 1'b1;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_type = 2'b00;
    bus.req_addr = '0; bus.req_wdata = '0; bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    step();
    step();
    chk_all_zero("reset");
    reset = 1'b0;
    step();

    for (int i = 0; i < 14; i++) run_vec(i, vecs[i]);

    // stray ack while idle must be ignored
    bus.mem_ack = 1'b1;
    bus.mem_rdata = 32'hFFFF_FFFF;
    step();
    step();
    chk("idle_ack_valid", 32'(bus.resp_valid), 32'd0);
    chk("idle_ack_req", 32'(bus.mem_req), 32'd0);
    bus.mem_ack = 1'b0;

    // request presented during DONE is dropped
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_type = 2'b00; bus.req_addr = 32'h0000_0002;
    step();
    chk("done_valid", 32'(bus.resp_valid), 32'd1);
    chk("done_stall", 32'(bus.stall), 32'd0);
    bus.req_addr = 32'h0000_D000;
    step();
    bus.req_valid = 1'b0;
    chk("done_ignore_req", 32'(bus.mem_req), 32'd0);
    chk("done_one_cycle", 32'(bus.resp_valid), 32'd0);
    step();
    chk("done_ignore_req2", 32'(bus.mem_req), 32'd0);

    // reset together with ack on the third WAIT cycle
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_type = 2'b00;
    bus.req_addr = 32'h0000_B000; bus.req_wdata = 32'hA5A5_A5A5;
    step();
    bus.req_valid = 1'b0;
    chk("rst_wait1_req", 32'(bus.mem_req), 32'd1);
    step();
    step();
    chk("rst_wait3_req", 32'(bus.mem_req), 32'd1);
    reset = 1'b1;
    bus.mem_ack = 1'b1;
    step();
    reset = 1'b0;
    bus.mem_ack = 1'b0;
    chk_all_zero("rst_mid");
    step();
    chk("rst_after_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_after_req", 32'(bus.mem_req), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dm_ctrl.md
DM_CTRL -- requirements
Module: dm_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-002 SHALL have: reset  in  1  synchronous, active-high; sampled only on rising clk.
REQ-003 SHALL have: req_valid  in  1  MEM-stage access request; req_we  in  1  1=store, 0=load.
REQ-004 SHALL have: req_type  in  2  00 word, 01 half, 10 byte, 11 illegal.
REQ-005 SHALL have: req_addr  in  32  byte address; req_wdata  in  32  store data, low-aligned.
REQ-006 SHALL have: stall  out  1  freeze pipeline; resp_valid  out  1  access complete; resp_err  out  1  misaligned, illegal or timeout.
REQ-007 SHALL have: resp_rdata  out  32  sign-extended load result.
REQ-008 SHALL have: mem_req  out  1; mem_we  out  1; mem_addr  out  32  word-aligned, [1:0]=00; mem_byteen  out  4; mem_wdata  out  32.
REQ-009 SHALL have: mem_ack  in  1  memory completion; mem_rdata  in  32  full word, valid when mem_ack=1.

Function
REQ-010 SHALL implement states IDLE, WAIT, DONE.
REQ-011 IDLE, req_valid=0: SHALL remain IDLE.
REQ-012 IDLE, req_valid=1, error: SHALL go to DONE with resp_err=1, no mem_req. Error means req_type=11, word with addr[1:0]!=0, or half with addr[0]=1.
REQ-013 IDLE, req_valid=1, legal: SHALL latch mem_we, mem_addr={addr[31:2],2'b00}, mem_byteen, mem_wdata and type/offset, then go to WAIT; mem_req=1 from the next cycle.
REQ-014 mem_byteen SHALL be: word 1111; half 0011 if addr[1]=0, else 1100; byte 1<<addr[1:0]. Loads use the same enables.
REQ-015 mem_wdata SHALL be: word wdata; half {2{wdata[15:0]}}; byte {4{wdata[7:0]}}.
REQ-016 WAIT: mem_req=1 SHALL be held; mem_addr, mem_byteen, mem_wdata and mem_we SHALL stay stable until the exit cycle.
REQ-017 WAIT with mem_ack=1: SHALL register resp_rdata and go to DONE with resp_err=0.
REQ-018 Load data SHALL be: word mem_rdata; half the sign-extended halfword at addr[1]; byte the sign-extended byte at addr[1:0].
REQ-019 Store responses SHALL drive resp_rdata=0.
REQ-020 A 4-bit wait counter SHALL clear on WAIT entry and increment each WAIT cycle without mem_ack.
REQ-021 If the counter reaches 15 with no mem_ack, the next edge SHALL go to DONE with resp_err=1 and resp_rdata=0; mem_req falls that edge. Timeout = 16 WAIT cycles.
REQ-022 mem_ack on the 16th WAIT cycle SHALL count as success; ack wins over timeout.
REQ-023 DONE: resp_valid=1 for exactly one cycle, then IDLE unconditionally; req_valid in DONE SHALL be ignored.
REQ-024 stall SHALL be combinational: (IDLE and req_valid) or WAIT; stall=0 in DONE.
REQ-025 mem_ack outside WAIT SHALL be ignored.
REQ-026 Minimum latency SHALL be: request cycle, one WAIT cycle with ack, DONE = resp_valid 2 cycles after the request cycle.
REQ-027 mem_req, resp_valid and resp_err SHALL be registered, glitch-free outputs.

Reset
REQ-028 reset=1 SHALL force IDLE with mem_req=0, mem_we=0, mem_addr=0, mem_byteen=0, mem_wdata=0, resp_valid=0, resp_err=0, resp_rdata=0, counter=0, all on the next edge.
REQ-029 Reset SHALL override every transition, including mid-WAIT; a pending mem_ack in that cycle SHALL be discarded.
REQ-030 stall SHALL be 0 while in reset-forced IDLE with req_valid=0.

Verification
REQ-031 Byte load: type=10, addr=0x1003, mem_rdata=0x80FF_1234, ack on first WAIT cycle -> mem_addr=0x1000, byteen=1000, resp_rdata=0xFFFF_FF80 two cycles after the request.
REQ-032 Half store: type=01, addr=0x2002, wdata=0x0000_BEEF -> mem_byteen=1100, mem_wdata=0xBEEF_BEEF, mem_we=1, resp_rdata=0.
REQ-033 Misaligned word load: addr=0x3001 -> no mem_req; next cycle resp_valid=1, resp_err=1; stall high for 1 cycle.
REQ-034 Timeout: legal load, mem_ack never asserted -> mem_req high exactly 16 cycles, then resp_valid=1, resp_err=1.
REQ-035 Ack on 16th WAIT cycle: half load at addr=0x4000, mem_rdata=0x0000_7FFF -> resp_err=0, resp_rdata=0x0000_7FFF.
REQ-036 reset asserted on 3rd WAIT cycle together with mem_ack -> next cycle IDLE, all outputs 0, no resp_valid.
